// File: rtl/score_bcd_serial.sv
// score_bcd_serial: serial 9-bit binary to 3-digit BCD converter (double dabble).
// A capture in IDLE is followed by nine SHIFT edges and one DONE edge, so the
// result lands on oBCD ten edges after the capture, together with a one-cycle
// oDone pulse.
// Optional build macro: SCORE_BCD_BLANK_EN enables leading-zero blanking
// (blank digit shown as 4'hF) on the value loaded into oBCD.

// One BCD digit correction step: digits of 5 or more get 3 added so the
// following left shift carries correctly into the next decade.
module scoreBcdAdd3 (
  input  logic [3:0] digitIn,
  output logic [3:0] digitOut
);
  // add-3 correction for a single decade
  always_comb digitOut = (digitIn >= 4'd5) ? digitIn + 4'd3 : digitIn;
endmodule

module score_bcd_serial (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iStart,
  input  logic [8:0]  iBinario,
  output logic        oBusy,
  output logic        oDone,
  output logic [11:0] oBCD
);
  localparam int NUM_DIGITS = 3;
  localparam int BIN_W      = 9;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]                  state;
  logic [BIN_W-1:0]            shiftReg;
  logic [3:0]                  count;
  logic [NUM_DIGITS-1:0][3:0]  scratch;
  logic [NUM_DIGITS-1:0][3:0]  scratchAdj;
  logic [NUM_DIGITS-1:0][3:0]  bcdLoad;

  // per-digit correction ahead of each shift
  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : gDigit
      scoreBcdAdd3 uAdd3 (
        .digitIn  (scratch[g]),
        .digitOut (scratchAdj[g])
      );
    end
  endgenerate

  // value presented to oBCD at completion; blanking only touches this copy,
  // the scratch register always holds the raw digits
  always_comb begin
    bcdLoad = scratch;
`ifdef SCORE_BCD_BLANK_EN
    if (scratch[2] == 4'd0) begin
      bcdLoad[2] = 4'hF;
      if (scratch[1] == 4'd0) bcdLoad[1] = 4'hF;
    end
`endif
  end

  assign oBusy = (state != IDLE);

  // conversion FSM; oBCD only changes on a DONE edge or reset, so the display
  // never sees the intermediate scratch contents
  always_ff @(posedge iClk) begin
    if (!iReset) begin
      state    <= IDLE;
      shiftReg <= '0;
      scratch  <= '0;
      count    <= '0;
      oBCD     <= '0;
      oDone    <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            shiftReg <= iBinario;
            scratch  <= '0;
            count    <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, shiftReg} <= {scratchAdj, shiftReg} << 1;
          count <= count + 4'd1;
          // count==8 means this edge performs the ninth shift
          if (count == 4'd8) state <= DONE;
        end
        DONE: begin
          oBCD  <= bcdLoad;
          oDone <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_score_bcd_serial.sv
// Scoreboard bench for score_bcd_serial: the driver pushes expected value and
// due cycle at each capture, the monitor pops and compares on every oDone.
module tb_score_bcd_serial;
  logic        iClk = 1'b0;
  logic        iReset;
  logic        iStart;
  logic [8:0]  iBinario;
  logic        oBusy;
  logic        oDone;
  logic [11:0] oBCD;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int doneCount = 0;
  logic rstAtEdge = 1'b0;
  logic [11:0] prevBcd = 12'h000;
  int expVal[$];
  int expDue[$];
  int mVal, mDue;

  score_bcd_serial dut (
    .iClk     (iClk),
    .iReset   (iReset),
    .iStart   (iStart),
    .iBinario (iBinario),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oBCD     (oBCD)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) begin
    cyc       <= cyc + 1;
    rstAtEdge <= iReset;
  end

  function automatic logic [11:0] model(int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
`ifdef SCORE_BCD_BLANK_EN
    if (h == 4'd0) begin
      h = 4'hF;
      if (t == 4'd0) t = 4'hF;
    end
`endif
    return {h, t, u};
  endfunction

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitor: compare every completion against the scoreboard
  always @(negedge iClk) begin
    if (oDone) begin
      doneCount++;
      if (expVal.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got bcd=%h want no pulse", oBCD);
      end else begin
        mVal = expVal.pop_front();
        mDue = expDue.pop_front();
        check($sformatf("bcd(%0d)", mVal), int'(oBCD), int'(model(mVal)));
        check($sformatf("latency(%0d)", mVal), cyc, mDue);
      end
    end
    if (oBCD !== prevBcd) begin
      checks++;
      if (!oDone && rstAtEdge) begin
        errors++;
        $display("FAIL bcd_hold got %h want %h", oBCD, prevBcd);
      end
      prevBcd = oBCD;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic waitIdle();
    int k = 0;
    while ((oBusy || expVal.size() != 0) && k < 60) begin
      @(negedge iClk);
      k++;
    end
    if (k >= 60) begin
      checks++;
      errors++;
      $display("FAIL wait_idle got busy=%b pending=%0d want idle", oBusy, expVal.size());
    end
  endtask

  // one-cycle start; on return we sit at the negedge after the capture edge
  task automatic startConv(int v, bit push);
    waitIdle();
    iBinario = 9'(v);
    iStart   = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    if (push) begin
      expVal.push_back(v);
      expDue.push_back(cyc + 10);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0, busyN, c0;
    int b2b[3] = '{99, 100, 450};

    // reset with iStart high: reset wins
    iReset = 1'b0; iStart = 1'b1; iBinario = 9'd0;
    tick(3);
    check("rst_bcd", int'(oBCD), 0);
    check("rst_done", int'(oDone), 0);
    check("rst_busy", int'(oBusy), 0);
    iStart = 1'b0; iReset = 1'b1;
    tick(2);

    // basic directed values
    startConv(0, 1);
    startConv(9, 1);
    startConv(255, 1);
    startConv(511, 1);
    startConv(105, 1);
    startConv(7, 1);
    waitIdle();

    // start pulse mid-conversion with a new value must be ignored
    dc0 = doneCount;
    waitIdle();
    iBinario = 9'd123; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    expVal.push_back(123);
    expDue.push_back(cyc + 10);
    busyN = 0;
    for (int k = 0; k < 30; k++) begin
      if (!oBusy) break;
      busyN++;
      if (k == 2) begin iStart = 1'b1; iBinario = 9'd300; end
      if (k == 3) iStart = 1'b0;
      @(negedge iClk);
    end
    check("busy_cycles", busyN, 10);
    tick(20);
    check("single_done", doneCount - dc0, 1);

    // reset at the fifth shift edge aborts the conversion
    dc0 = doneCount;
    startConv(77, 0);
    tick(4);
    iReset = 1'b0;
    tick(1);
    check("abort_busy", int'(oBusy), 0);
    check("abort_bcd", int'(oBCD), 0);
    check("abort_done", int'(oDone), 0);
    iReset = 1'b1;
    tick(15);
    check("abort_no_done", doneCount - dc0, 0);
    startConv(42, 1);
    waitIdle();

    // iStart held high: one conversion every 11 cycles
    tick(1);
    iStart = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iBinario = 9'(b2b[k]);
      expVal.push_back(b2b[k]);
      expDue.push_back(cyc + 11);
      tick(11);
    end
    iStart = 1'b0;
    c0 = doneCount;
    waitIdle();
    tick(3);
    check("b2b_idle", int'(oBusy), 0);

    // exhaustive sweep
    dc0 = doneCount;
    for (int v = 0; v < 512; v++) startConv(v, 1);
    waitIdle();
    tick(3);
    check("sweep_done_count", doneCount - dc0, 512);
    check("queue_empty", expVal.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/score_bcd_serial.md
SCORE_BCD_SERIAL -- requirements
Module: score_bcd_serial

Interface
REQ-001 SHALL provide ports: iClk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL provide: iReset  input  1  synchronous, active-low reset, sampled on the iClk rising edge.
REQ-003 SHALL provide: iStart  input  1  request to convert iBinario; honoured only in IDLE.
REQ-004 SHALL provide: iBinario  input  9  unsigned score from the point counter, 0..511.
REQ-005 SHALL provide: oBusy  output  1  high whenever state is not IDLE.
REQ-006 SHALL provide: oDone  output  1  registered one-cycle pulse on each completed conversion.
REQ-007 SHALL provide: oBCD  output  12  [11:8] hundreds, [7:4] tens, [3:0] units; feeds the 7-segment display multiplexer.

Function
REQ-008 SHALL implement an FSM with states IDLE, SHIFT and DONE, using serial shift-and-add-3 (double dabble).
REQ-009 In IDLE, iStart=1 at a rising edge SHALL capture iBinario into a 9-bit shift register, clear the 12-bit scratch BCD, clear the 4-bit iteration counter and enter SHIFT.
REQ-010 In SHIFT, each edge SHALL first add 3 to every scratch digit >= 5, then shift {scratch, shift register} left one bit, then increment the counter.
REQ-011 SHIFT SHALL last exactly 9 edges; the edge performing the 9th shift SHALL move the FSM to DONE.
REQ-012 In DONE, the next edge SHALL load oBCD from scratch, set oDone=1 and return to IDLE; oDone SHALL clear on the following edge.
REQ-013 Latency: with iStart captured at edge E0, oBCD and oDone SHALL both update at edge E10; a new iStart SHALL be accepted no earlier than edge E11.
REQ-014 iStart during SHIFT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-015 iBinario SHALL be sampled only at capture; later changes SHALL NOT affect an ongoing conversion.
REQ-016 oBCD SHALL hold its last value between completions and SHALL NOT show intermediate scratch values.
REQ-017 Every digit of oBCD SHALL be 0..9 for all inputs 0..511 when blanking is disabled.
REQ-018 iStart held high continuously SHALL produce back-to-back conversions, one every 11 cycles.

Reset
REQ-019 iReset=0 at an edge SHALL force IDLE and set oBCD=12'h000, oDone=0, oBusy=0, counter=0 and scratch=0.
REQ-020 Reset mid-conversion SHALL abort the conversion with no oDone pulse, and oBCD SHALL read 12'h000.
REQ-021 If iReset=0 and iStart=1 occur at the same edge, reset SHALL win and no conversion SHALL start.

Configuration
REQ-022 Macro SCORE_BCD_BLANK_EN, when defined, SHALL enable leading-zero blanking at the oBCD load in REQ-012: hundreds=0 SHALL be output as 4'hF; tens SHALL be output as 4'hF when both hundreds and tens are 0; units SHALL never be blanked.
REQ-023 Without SCORE_BCD_BLANK_EN, oBCD SHALL equal the raw scratch digits; timing SHALL be identical in both builds, and the reset value SHALL remain 12'h000 in both builds.

Verification
REQ-024 SHALL cover: reset, then iBinario=0 with a 1-cycle iStart -> oDone pulse 10 edges later, oBCD=12'h000 (12'hFF0 with SCORE_BCD_BLANK_EN).
REQ-025 SHALL cover: iBinario=9, 255, 511 in sequence -> oBCD=12'h009, 12'h255, 12'h511 (blank build: 12'hFF9, 12'h255, 12'h511).
REQ-026 SHALL cover: iBinario=105 -> oBCD=12'h105 in both builds (inner zero not blanked); iBinario=7 in blank build -> 12'hFF7.
REQ-027 SHALL cover: iStart pulsed 3 edges after a capture, with iBinario changed to 300 -> single oDone, oBCD reflects the original value, oBusy high for exactly 10 cycles.
REQ-028 SHALL cover: iReset=0 at the 5th SHIFT edge -> no oDone, oBCD=12'h000, oBusy=0; the next iStart with 42 -> oBCD=12'h042 after 10 edges.
REQ-029 SHALL cover: an exhaustive sweep of 0..511 against a reference model -> all digits match with no mismatch, and the oDone count equals 512.
